div_rs: RTL and testbench

Unsigned repeated-subtraction divider, the inverse counterpart to the team's repeated-addition multiplier. A start pulse captures a dividend and divisor. The block then subtracts the divisor from a running remainder once per clock, incrementing a quotient counter until the remainder is smaller than the divisor. It uses the same start/done, controller-plus-datapath style as the multiplier and sits beside it in the arithmetic unit.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_datapath.sv | 57 +++++
 rtl/div_rs.sv | 84 ++++++++
 tb/tb_div_rs.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package div_pkg;

  localparam int unsigned DivWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_datapath.sv
// Remainder/divisor/quotient registers with the subtractor, R>=D comparator and D==0 detector.
module div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             sub_i,
  input  logic             sat_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ge_o,
  output logic             dz_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;

  assign ge_o = (r_q >= d_q);
  assign dz_o = (d_q == '0);
  assign q_o  = q_q;
  assign r_o  = r_q;

  always_comb begin
    r_d = r_q;
    d_d = d_q;
    q_d = q_q;
    if (load_i) begin
      r_d = dividend_i;
      d_d = divisor_i;
      q_d = '0;
    end else if (sat_i) begin
      q_d = '1;
    end else if (sub_i) begin
      r_d = r_q - d_q;
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
    end else begin
      r_q <= r_d;
      d_q <= d_d;
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/div_rs.sv
// Unsigned repeated-subtraction divider: start/done controller around div_datapath.
module div_rs
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e state_q, state_d;
  logic       dbz_q, dbz_d;
  logic       load, sub, sat;
  logic       ge, dz;

  div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (load),
    .sub_i      (sub),
    .sat_i      (sat),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .ge_o       (ge),
    .dz_o       (dz),
    .q_o        (quotient),
    .r_o        (remainder)
  );

  always_comb begin
    state_d = state_q;
    dbz_d   = dbz_q;
    load    = 1'b0;
    sub     = 1'b0;
    sat     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          load    = 1'b1;
          dbz_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Zero divisor must win, otherwise R>=0 would subtract forever.
        if (dz) begin
          sat     = 1'b1;
          dbz_d   = 1'b1;
          state_d = StDone;
        end else if (ge) begin
          sub = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_rs.sv
// Scoreboard bench for div_rs: stimulus pushes expected results, a negedge monitor checks them.
module tb_div_rs;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  div_rs #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           accept;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: measure busy length and check every completed division against the scoreboard.
  logic done_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   busy_cnt  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_prev) busy_cnt = 0;
    if (busy) busy_cnt++;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done rose at cycle %0d with no pending request", cyc);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        check("latency", 32'(cyc - e.accept), 32'(e.lat));
        check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        check("busy_done_exclusive", 32'(busy & done), 32'd0);
      end
    end
    done_prev = done;
    busy_prev = busy;
  end

  // Drive one start pulse; optionally push the expected result. Returns at the negedge after edge 0.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic push,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input int elat);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz; e.lat = elat; e.accept = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done) return;
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL done_timeout: no done within %0d cycles, expected done=1", bound);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_remainder"}, 32'(remainder), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    issue(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 1'b0, 15);
    wait_done(40);
    issue(16'd5, 16'd9, 1'b1, 16'd0, 16'd5, 1'b0, 1);
    wait_done(10);
    issue(16'd7, 16'd0, 1'b1, 16'hFFFF, 16'd7, 1'b1, 1);
    wait_done(10);
    issue(16'd48, 16'd16, 1'b1, 16'd3, 16'd0, 1'b0, 4);
    wait_done(10);
    issue(16'd65535, 16'd1, 1'b1, 16'd65535, 16'd0, 1'b0, 65536);
    wait_done(70000);

    // Start pulse mid-RUN must not disturb 1000/3.
    issue(16'd1000, 16'd3, 1'b1, 16'd333, 16'd1, 1'b0, 334);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 16'd4;
    @(negedge clk);
    start = 1'b0;
    wait_done(400);
    issue(16'd9, 16'd4, 1'b1, 16'd2, 16'd1, 1'b0, 3);
    check("reload_done_drops", 32'(done), 32'd0);
    check("reload_busy", 32'(busy), 32'd1);
    wait_done(10);

    // Reset mid-RUN abandons the operation; nothing is pushed for it.
    issue(16'd1000, 16'd3, 1'b0, '0, '0, 1'b0, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrun_reset");
    rst_n = 1'b1;
    issue(16'd20, 16'd6, 1'b1, 16'd3, 16'd2, 1'b0, 4);
    wait_done(20);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
